// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit_if
//  Purpose  : Bundles the instruction-memory byte bus, the redirect request
//             and the decode valid/ready handshake of the fetch unit.
//  Modports : master - fetch unit side (drives memory address/enables,
//                      the decode head and the misalign flag)
//             slave  - environment side (memory data, redirect, decode ready)
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
   // Instruction memory bus
   logic [31:0] instr_addr;
   logic        instr_ce;
   logic        instr_oe;
   logic [7:0]  instr_in;
   // Redirect from decode/branch logic
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   // Decode handshake
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        misalign_err;

   modport master (
      output instr_addr, instr_ce, instr_oe,
      input  instr_in,
      input  redirect_valid, redirect_pc,
      output instr_valid, instr_data, instr_pc,
      input  instr_ready,
      output misalign_err
   );

   modport slave (
      input  instr_addr, instr_ce, instr_oe,
      output instr_in,
      output redirect_valid, redirect_pc,
      input  instr_valid, instr_data, instr_pc,
      output instr_ready,
      input  misalign_err
   );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : RV32I fetch front end. Reads each instruction as four bytes
//             over an 8-bit memory bus, assembles a little-endian word,
//             queues {word, pc} in a FIFO and hands it to decode through a
//             valid/ready handshake. A redirect flushes everything and
//             restarts fetch at the new (word-aligned) PC.
//  Ports    : clk   - system clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - instr_fetch_unit_if.master (memory, redirect, decode)
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          READ_LAT  = 1,
   parameter int          BUF_DEPTH = 2
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   instr_fetch_unit_if.master     bus
);

   localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t            state_q;
   logic [31:0]       fetch_pc_q;
   logic [31:0]       addr_q;
   logic              ce_q;
   logic [1:0]        idx_q;
   logic [LAT_W-1:0]  lat_q;
   logic [23:0]       word_q;      // bytes 0..2; byte 3 goes straight into the push
   logic [31:0]       buf_data_q [BUF_DEPTH];
   logic [31:0]       buf_pc_q   [BUF_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              misalign_q;

   logic              lat_done;
   logic              push;
   logic              pop;
   logic [PTR_W-1:0]  rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_d;

   // A single-entry buffer keeps both pointers pinned at zero.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (BUF_DEPTH == 1) return '0;
      else                return p + 1'b1;
   endfunction

   assign lat_done = (lat_q == LAT_LAST);
   assign push     = (state_q == FETCH) && lat_done && (idx_q == 2'd3);
   assign pop      = (count_q != '0) && bus.instr_ready;
   assign rd_ptr_d = ptr_inc(rd_ptr_q);
   assign wr_ptr_d = ptr_inc(wr_ptr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= '0;
         ce_q       <= 1'b0;
         idx_q      <= '0;
         lat_q      <= '0;
         word_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         misalign_q <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_data_q[i] <= '0;
            buf_pc_q[i]   <= '0;
         end
      end else if (bus.redirect_valid) begin
         // Redirect overrides any fetch progress, push or pop on this edge.
         state_q    <= IDLE;
         ce_q       <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         fetch_pc_q <= {bus.redirect_pc[31:2], 2'b00};
         misalign_q <= (bus.redirect_pc[1:0] != 2'b00);
      end else begin
         case (state_q)
            IDLE: begin
               // Only start when the word is guaranteed a free slot.
               if (count_q < DEPTH_C) begin
                  state_q <= FETCH;
                  addr_q  <= fetch_pc_q;
                  ce_q    <= 1'b1;
                  idx_q   <= '0;
                  lat_q   <= '0;
               end
            end
            FETCH: begin
               if (lat_done) begin
                  if (idx_q != 2'd3) begin
                     word_q[{idx_q, 3'b000} +: 8] <= bus.instr_in;
                     addr_q <= addr_q + 32'd1;
                     idx_q  <= idx_q + 2'd1;
                     lat_q  <= '0;
                  end else begin
                     fetch_pc_q <= fetch_pc_q + 32'd4;
                     ce_q       <= 1'b0;
                     state_q    <= IDLE;
                  end
               end else begin
                  lat_q <= lat_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (push) begin
            buf_data_q[wr_ptr_q] <= {bus.instr_in, word_q};
            buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
            wr_ptr_q             <= wr_ptr_d;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_d;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.instr_addr   = addr_q;
   assign bus.instr_ce     = ce_q;
   assign bus.instr_oe     = ce_q;
   assign bus.instr_valid  = (count_q != '0);
   assign bus.instr_data   = buf_data_q[rd_ptr_q];
   assign bus.instr_pc     = buf_pc_q[rd_ptr_q];
   assign bus.misalign_err = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Self-checking bench for instr_fetch_unit. One instance runs
//             with READ_LAT=1 against a combinational byte memory, a second
//             with READ_LAT=3 against a two-stage delayed memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [31:0] rpc;
      logic        mis;
      logic [31:0] start;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic rst3_n;
   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs [4];
   logic [31:0] a3_d1, a3_d2;

   always #5 clk = ~clk;

   instr_fetch_unit_if bus1 ();
   instr_fetch_unit_if bus3 ();

   instr_fetch_unit #(.RESET_PC(32'h0), .READ_LAT(1), .BUF_DEPTH(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.master)
   );

   instr_fetch_unit #(.RESET_PC(32'h0), .READ_LAT(3), .BUF_DEPTH(2)) u_dut3 (
      .clk   (clk),
      .rst_n (rst3_n),
      .bus   (bus3.master)
   );

   // Memory contents: first word is a real RV32I lw, the rest a byte hash.
   function automatic logic [7:0] mb(input logic [31:0] a);
      case (a)
         32'd0:   return 8'h83;
         32'd1:   return 8'hA6;
         32'd2:   return 8'h00;
         32'd3:   return 8'h00;
         default: return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [31:0] mw(input logic [31:0] pc);
      return {mb(pc + 32'd3), mb(pc + 32'd2), mb(pc + 32'd1), mb(pc)};
   endfunction

   function automatic exp_t mk(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.data = mw(pc);
      return e;
   endfunction

   assign bus1.instr_in = mb(bus1.instr_addr);

   always @(posedge clk) begin
      a3_d1 <= bus3.instr_addr;
      a3_d2 <= a3_d1;
   end
   assign bus3.instr_in = mb(a3_d2);

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect1(input logic [31:0] pc);
      bus1.redirect_valid = 1'b1;
      bus1.redirect_pc    = pc;
      tick();
      bus1.redirect_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check32("drain_left", sb_q.size(), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check32({tag, "_addr"},  bus1.instr_addr,   32'h0);
      check32({tag, "_ce"},    bus1.instr_ce,     32'h0);
      check32({tag, "_oe"},    bus1.instr_oe,     32'h0);
      check32({tag, "_valid"}, bus1.instr_valid,  32'h0);
      check32({tag, "_data"},  bus1.instr_data,   32'h0);
      check32({tag, "_pc"},    bus1.instr_pc,     32'h0);
      check32({tag, "_mis"},   bus1.misalign_err, 32'h0);
   endtask

   // Scoreboard: each accepted head is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus1.instr_valid && bus1.instr_ready && !bus1.redirect_valid
          && sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         check32("sb_pc",   bus1.instr_pc,   mon_e.pc);
         check32("sb_data", bus1.instr_data, mon_e.data);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{rpc: 32'h0000_0202, mis: 1'b1, start: 32'h0000_0200};
      vecs[1] = '{rpc: 32'h0000_0300, mis: 1'b0, start: 32'h0000_0300};
      vecs[2] = '{rpc: 32'hFFFF_FFFE, mis: 1'b1, start: 32'hFFFF_FFFC};
      vecs[3] = '{rpc: 32'h0000_1001, mis: 1'b1, start: 32'h0000_1000};

      rst_n  = 1'b0;
      rst3_n = 1'b0;
      bus1.redirect_valid = 1'b0;
      bus1.redirect_pc    = 32'h0;
      bus1.instr_ready    = 1'b0;
      bus3.redirect_valid = 1'b0;
      bus3.redirect_pc    = 32'h0;
      bus3.instr_ready    = 1'b0;
      repeat (3) tick();
      check_reset_outputs("rst");

      // First fetch after reset: byte addresses 0..3, word out 5 edges later.
      bus1.instr_ready = 1'b1;
      sb_q.push_back(mk(32'h0));
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check32("first_addr", bus1.instr_addr, 32'(k));
         if (k == 0) begin
            check32("first_ce", bus1.instr_ce, 32'h1);
            check32("first_oe", bus1.instr_oe, 32'h1);
         end
      end
      check32("valid_before_push", bus1.instr_valid, 32'h0);
      tick();
      check32("first_valid", bus1.instr_valid, 32'h1);
      check32("first_data",  bus1.instr_data,  32'h0000_A683);
      check32("first_pc",    bus1.instr_pc,    32'h0);
      tick();
      check32("second_start", bus1.instr_addr, 32'h4);

      // Back-pressure: two words fill the buffer, then fetch stalls.
      bus1.instr_ready = 1'b0;
      redirect1(32'h0);
      repeat (14) tick();
      check32("full_ce",    bus1.instr_ce,    32'h0);
      check32("full_valid", bus1.instr_valid, 32'h1);
      check32("full_head",  bus1.instr_pc,    32'h0);
      sb_q.push_back(mk(32'h0));
      sb_q.push_back(mk(32'h4));
      sb_q.push_back(mk(32'h8));
      bus1.instr_ready = 1'b1;
      tick();
      check32("pop1_head", bus1.instr_pc, 32'h4);
      tick();
      check32("pop2_valid", bus1.instr_valid, 32'h0);
      check32("resume_addr", bus1.instr_addr, 32'h8);
      check32("resume_ce",   bus1.instr_ce,   32'h1);
      drain(20);

      // Redirect mid-word, held two cycles: last target wins, nothing starts.
      sb_q.delete();
      redirect1(32'h40);
      repeat (3) tick();
      check32("mid_addr", bus1.instr_addr, 32'h42);
      sb_q.push_back(mk(32'h100));
      bus1.redirect_valid = 1'b1;
      bus1.redirect_pc    = 32'h500;
      tick();
      check32("abort_ce",    bus1.instr_ce,    32'h0);
      check32("abort_valid", bus1.instr_valid, 32'h0);
      bus1.redirect_pc = 32'h100;
      tick();
      check32("held_ce", bus1.instr_ce, 32'h0);
      bus1.redirect_valid = 1'b0;
      tick();
      check32("redir_addr", bus1.instr_addr, 32'h100);
      check32("redir_ce",   bus1.instr_ce,   32'h1);
      drain(20);

      // Redirect table: alignment flag, aligned start address, wrap-around.
      for (int i = 0; i < 4; i++) begin
         sb_q.delete();
         sb_q.push_back(mk(vecs[i].start));
         sb_q.push_back(mk(vecs[i].start + 32'd4));
         redirect1(vecs[i].rpc);
         check32("tbl_mis", bus1.misalign_err, 32'(vecs[i].mis));
         tick();
         check32("tbl_start", bus1.instr_addr, vecs[i].start);
         drain(30);
      end

      // Asynchronous reset mid-fetch with misalign_err set.
      sb_q.delete();
      redirect1(32'h82);
      repeat (2) tick();
      check32("pre_rst_mis", bus1.misalign_err, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      sb_q.push_back(mk(32'h0));
      tick();
      rst_n = 1'b1;
      tick();
      check32("restart_addr", bus1.instr_addr, 32'h0);
      check32("restart_ce",   bus1.instr_ce,   32'h1);
      drain(20);

      // READ_LAT=3 instance: address hold, push timing, push+pop same edge.
      @(posedge clk);
      #2;
      rst3_n = 1'b1;
      tick();
      check32("l3_start_addr", bus3.instr_addr, 32'h0);
      check32("l3_start_ce",   bus3.instr_ce,   32'h1);
      repeat (2) tick();
      check32("l3_hold_addr", bus3.instr_addr, 32'h0);
      tick();
      check32("l3_next_addr", bus3.instr_addr, 32'h1);
      repeat (8) tick();
      check32("l3_valid_e11", bus3.instr_valid, 32'h0);
      tick();
      check32("l3_valid_e12", bus3.instr_valid, 32'h1);
      check32("l3_pc_e12",    bus3.instr_pc,    32'h0);
      check32("l3_data_e12",  bus3.instr_data,  mw(32'h0));
      repeat (12) tick();
      bus3.instr_ready = 1'b1;
      tick();
      bus3.instr_ready = 1'b0;
      check32("l3_pp_valid", bus3.instr_valid, 32'h1);
      check32("l3_pp_pc",    bus3.instr_pc,    32'h4);
      check32("l3_pp_data",  bus3.instr_data,  mw(32'h4));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch front end for the RV32I core.
- Reads instructions one byte at a time over the 8-bit instruction memory bus and assembles each into a 32-bit little-endian word.
- Queues each word, tagged with its PC, in a small buffer. The decode stage consumes it through a valid/ready handshake.
- Decode or branch logic can redirect the fetch PC at any time, which flushes the buffer and aborts any fetch in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- READ_LAT, 1, cycles from driving instr_addr to the clock edge where instr_in holds that byte. Must be >= 1.
- BUF_DEPTH, 2, instruction buffer entries. Power of two, >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_addr  out  32  byte address to instruction memory.
- instr_ce  out  1  memory chip enable, active high.
- instr_oe  out  1  memory output enable, active high.
- instr_in  in  8  byte returned by memory.
- redirect_valid  in  1  load new fetch PC (branch/jump taken).
- redirect_pc  in  32  new fetch PC.
- instr_valid  out  1  buffer head valid.
- instr_ready  in  1  decode accepts head.
- instr_data  out  32  head instruction.
- instr_pc  out  32  PC of head instruction.
- misalign_err  out  1  sticky flag: last redirect target had pc[1:0] != 0.

Behaviour:
- Reset values: instr_addr=0, instr_ce=0, instr_oe=0, instr_valid=0, instr_data=0, instr_pc=0, misalign_err=0. Buffer is empty, fetch_pc=RESET_PC, FSM is IDLE.
- Reset asserted mid-fetch aborts immediately, with no partial push.
- FSM states are IDLE and FETCH.
- IDLE -> FETCH on an edge where redirect_valid=0 and count < BUF_DEPTH. On that edge:
  - instr_addr <= fetch_pc.
  - instr_ce, instr_oe <= 1.
  - byte index <= 0, latency counter <= 0.
- FETCH: the latency counter increments each cycle. On the edge where the counter equals READ_LAT-1, instr_in is captured into byte [8*idx +: 8]:
  - If idx < 3: instr_addr <= instr_addr+1, idx++, counter <= 0.
  - If idx == 3: push {assembled word, fetch_pc} into the buffer, fetch_pc <= fetch_pc+4, instr_ce and instr_oe <= 0, and the FSM returns to IDLE.
- Timing: the push occurs 4*READ_LAT edges after the start edge. instr_valid rises in the following cycle.
- Sustained throughput is one instruction per 4*READ_LAT+1 cycles.
- Only one fetch is in flight at a time. Because a fetch starts only when count < BUF_DEPTH, a completing fetch never overflows the buffer.
- Buffer is a FIFO:
  - instr_valid = (count != 0). instr_data and instr_pc show the head entry and are stable while instr_valid=1 and instr_ready=0.
  - A pop occurs on an edge with instr_valid & instr_ready.
  - Push and pop on the same edge leave count unchanged. A pop on an empty buffer is ignored.
- Redirect (redirect_valid=1 at an edge) has highest priority:
  - Buffer is flushed (count=0) and any simultaneous pop or push is discarded.
  - An in-flight fetch is aborted, instr_ce and instr_oe <= 0, and the FSM goes to IDLE.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - misalign_err <= (redirect_pc[1:0] != 0).
  - The new fetch starts on the next edge (if redirect_valid is low then).
- Repeated redirects on consecutive cycles: the last one wins. No fetch starts while redirect_valid is held high.
- fetch_pc and instr_addr wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Test Plan:
- Reset, READ_LAT=1, memory bytes 0..3 = 83 A6 00 00, instr_ready=1 -> instr_addr sequence 0,1,2,3. instr_valid rises 5 cycles after reset release with instr_data=32'h0000A683 and instr_pc=0. The next fetch starts at address 4.
- instr_ready=0, BUF_DEPTH=2 -> exactly two instructions are buffered (pc 0 and 4), then instr_ce stays 0. Raising instr_ready pops pc 0 first, and the next fetch resumes at 8.
- Redirect to 32'h0000_0100 while fetching byte 2 -> partial word discarded and buffer emptied. Next start edge drives instr_addr=32'h100, and the first instruction out has instr_pc=32'h100.
- Redirect to 32'h0000_0202 -> misalign_err=1 and fetch from 32'h200. A later redirect to 32'h300 clears misalign_err.
- READ_LAT=3 -> each byte address is held 3 cycles and the push lands 12 edges after start. Push and pop on the same edge with count=1 keeps count=1 and instr_valid=1.
- rst_n pulsed low asynchronously mid-fetch -> all outputs return to their reset values immediately, and fetch restarts from RESET_PC after release.
